// File: rtl/mem_pkg.sv
// Shared encodings and widths for the main-memory line-fill responder.
package mem_pkg;

    localparam int unsigned LINE_BEATS = 4;
    localparam int unsigned BEAT_W     = 32;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'b00;
    localparam state_t StWait  = 2'b01;
    localparam state_t StBurst = 2'b10;
    localparam state_t StDone  = 2'b11;

    localparam logic [1:0] LastBeatCnt = 2'(LINE_BEATS - 1);

    function automatic logic [1:0] next_beat(input logic [1:0] beat);
        return beat + 2'd1;
    endfunction

endpackage

// File: rtl/main_mem_responder_if.sv
// Requester-side line-fill handshake: level request in, beat strobes out.
interface main_mem_responder_if;
    import mem_pkg::*;

    logic              mem_req;
    logic [31:0]       req_addr;
    logic              mem_ready;
    logic [BEAT_W-1:0] mem_data;
    logic [1:0]        write_num;

    modport master (output mem_req, req_addr, input mem_ready, mem_data, write_num);
    modport slave  (input mem_req, req_addr, output mem_ready, mem_data, write_num);

endinterface

// File: rtl/mem_latency_counter.sv
// 4-bit access-latency countdown with load, decrement and zero flag.
module mem_latency_counter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory responder returning a 4-beat line per request.
// Define MEM_CRITICAL_WORD_FIRST_EN to start each burst at the requested word.
module main_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    main_mem_responder_if.slave  bus,
    output logic                 busy_out,
    output logic                 arr_rd_en,
    output logic [29:0]          arr_addr,
    input  logic [BEAT_W-1:0]    arr_data
);

    localparam logic [3:0] LoadVal = 4'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [1:0]  beat_q, beat_d;
    logic [1:0]  beats_q, beats_d;
    logic [1:0]  first_beat;
    logic [1:0]  rd_word;
    logic        cnt_load, cnt_dec, cnt_zero;
    logic        unused_addr_bits;

`ifdef MEM_CRITICAL_WORD_FIRST_EN
    assign first_beat = bus.req_addr[3:2];
`else
    assign first_beat = 2'b00;
`endif

    assign unused_addr_bits = ^{bus.req_addr[3:0], addr_q[1:0]};

    assign cnt_load = (state_q == StIdle) && bus.mem_req;
    assign cnt_dec  = (state_q == StWait);

    mem_latency_counter u_lat_cnt (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (cnt_load),
        .load_val_i(LoadVal),
        .dec_i     (cnt_dec),
        .zero_o    (cnt_zero)
    );

    // Reads are issued one cycle ahead of the beat that carries their data.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        beats_d   = beats_q;
        arr_rd_en = 1'b0;
        rd_word   = beat_q;
        unique case (state_q)
            StIdle: begin
                if (bus.mem_req) begin
                    state_d = StWait;
                    addr_d  = bus.req_addr[31:2];
                    beat_d  = first_beat;
                    beats_d = 2'd0;
                end
            end
            StWait: begin
                if (cnt_zero) begin
                    arr_rd_en = 1'b1;
                    state_d   = StBurst;
                end
            end
            StBurst: begin
                beat_d  = next_beat(beat_q);
                beats_d = beats_q + 2'd1;
                if (beats_q != LastBeatCnt) begin
                    arr_rd_en = 1'b1;
                    rd_word   = next_beat(beat_q);
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!bus.mem_req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= 30'd0;
            beat_q  <= 2'd0;
            beats_q <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            beats_q <= beats_d;
        end
    end

    assign arr_addr      = {addr_q[29:2], rd_word};
    assign busy_out      = (state_q != StIdle);
    assign bus.mem_ready = (state_q == StBurst);
    assign bus.mem_data  = (state_q == StBurst) ? arr_data : '0;
    assign bus.write_num = beat_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: LATENCY=4 and LATENCY=1 instances against a timing model.
module tb_main_mem_responder;

    localparam int L0 = 4;
    localparam int L1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_w [2];
    logic        req_w [2];
    logic [31:0] raddr_w [2];
    logic        rdy_w [2];
    logic [1:0]  wn_w [2];
    logic [31:0] data_w [2];
    logic        busy_w [2];
    logic        rd_w [2];
    logic [29:0] aaddr_w [2];
    logic [31:0] adata_q [2];

    main_mem_responder_if bus0 ();
    main_mem_responder_if bus1 ();

    main_mem_responder #(.LATENCY(L0)) dut0 (
        .clk      (clk),
        .reset_n  (rst_w[0]),
        .bus      (bus0),
        .busy_out (busy_w[0]),
        .arr_rd_en(rd_w[0]),
        .arr_addr (aaddr_w[0]),
        .arr_data (adata_q[0])
    );

    main_mem_responder #(.LATENCY(L1)) dut1 (
        .clk      (clk),
        .reset_n  (rst_w[1]),
        .bus      (bus1),
        .busy_out (busy_w[1]),
        .arr_rd_en(rd_w[1]),
        .arr_addr (aaddr_w[1]),
        .arr_data (adata_q[1])
    );

    assign bus0.mem_req  = req_w[0];
    assign bus0.req_addr = raddr_w[0];
    assign bus1.mem_req  = req_w[1];
    assign bus1.req_addr = raddr_w[1];
    assign rdy_w[0]  = bus0.mem_ready;
    assign rdy_w[1]  = bus1.mem_ready;
    assign wn_w[0]   = bus0.write_num;
    assign wn_w[1]   = bus1.write_num;
    assign data_w[0] = bus0.mem_data;
    assign data_w[1] = bus1.mem_data;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [29:0] a);
        return {2'b10, a};
    endfunction

    // Backing array: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            adata_q[d] <= rd_w[d] ? word_of(aaddr_w[d]) : 32'h0;
        end
    end

    // Transaction model: a request accepted at cycle a yields beats at a+L+1..a+L+4.
    bit         act [2];
    int         acc [2];
    logic [1:0] first_m [2];
    logic [27:0] line_m [2];
    int         ncyc = 0;
    int         beats_seen [2];

    function automatic int lat_of(input int d);
        return (d == 0) ? L0 : L1;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_w[d]) begin
                act[d] = 1'b0;
            end else if (!act[d]) begin
                if (req_w[d]) begin
                    act[d]    = 1'b1;
                    acc[d]    = ncyc;
                    line_m[d] = raddr_w[d][31:4];
`ifdef MEM_CRITICAL_WORD_FIRST_EN
                    first_m[d] = raddr_w[d][3:2];
`else
                    first_m[d] = 2'd0;
`endif
                end
            end else if ((ncyc - acc[d] >= lat_of(d) + 5) && !req_w[d]) begin
                act[d] = 1'b0;
            end
        end
        ncyc++;
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int k, lat;
            logic [1:0] w;
            lat = lat_of(d);
            if (rdy_w[d] === 1'b1) beats_seen[d]++;
            if (!rst_w[d]) begin
                chk("rst_ready", rdy_w[d], 0);
                chk("rst_busy", busy_w[d], 0);
                chk("rst_rd_en", rd_w[d], 0);
                chk("rst_data", data_w[d], 0);
            end else if (!act[d]) begin
                chk("idle_ready", rdy_w[d], 0);
                chk("idle_busy", busy_w[d], 0);
                chk("idle_rd_en", rd_w[d], 0);
            end else begin
                k = ncyc - acc[d];
                chk("busy", busy_w[d], 1);
                chk("ready", rdy_w[d], (k >= lat + 1 && k <= lat + 4) ? 1 : 0);
                chk("rd_en", rd_w[d], (k >= lat && k <= lat + 3) ? 1 : 0);
                if (k >= lat + 1 && k <= lat + 4) begin
                    w = 2'(first_m[d] + 2'(k - lat - 1));
                    chk("write_num", wn_w[d], w);
                    chk("mem_data", data_w[d], word_of({line_m[d], w}));
                end
                if (k >= lat && k <= lat + 3) begin
                    w = 2'(first_m[d] + 2'(k - lat));
                    chk("arr_addr", aaddr_w[d], {line_m[d], w});
                end
            end
        end
    end

    task automatic wait_idle(input int d);
        int n = 0;
        while (act[d] && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", act[d], 0);
    endtask

    initial begin
        int n, bs;
        rst_w[0] = 0; rst_w[1] = 0;
        req_w[0] = 0; req_w[1] = 0;
        raddr_w[0] = 0; raddr_w[1] = 0;
        beats_seen[0] = 0; beats_seen[1] = 0;
        #3;
        chk("lit_rst_ready", rdy_w[0], 0);
        chk("lit_rst_wn", wn_w[0], 0);
        chk("lit_rst_busy", busy_w[1], 0);
        @(negedge clk);
        rst_w[0] = 1; rst_w[1] = 1;
        repeat (2) @(negedge clk);

        // LATENCY=4 at 0x1000, request held through DONE for 5 extra cycles
        @(posedge clk); #1 req_w[0] = 1; raddr_w[0] = 32'h0000_1000;
        @(posedge clk);
        repeat (4) @(negedge clk);
        chk("lit_c4_ready", rdy_w[0], 0);
        chk("lit_c4_busy", busy_w[0], 1);
        @(negedge clk);
        chk("lit_c5_ready", rdy_w[0], 1);
        chk("lit_c5_wn", wn_w[0], 0);
        chk("lit_c5_data", data_w[0], 32'h8000_0400);
        chk("lit_c5_arr_addr", aaddr_w[0], 30'h401);
        raddr_w[0] = 32'hFFFF_FFF0;
        repeat (3) @(negedge clk);
        chk("lit_c8_wn", wn_w[0], 3);
        chk("lit_c8_data", data_w[0], 32'h8000_0403);
        repeat (5) @(negedge clk);
        chk("lit_done_busy", busy_w[0], 1);
        chk("lit_done_ready", rdy_w[0], 0);
        req_w[0] = 0;
        @(negedge clk);
        chk("lit_back_idle", busy_w[0], 0);
        chk("lit_beats_t1", beats_seen[0], 4);

        // Word 3 request: starts at word 0 unless critical-word-first is built in
        @(posedge clk); #1 req_w[0] = 1; raddr_w[0] = 32'h0000_100C;
        @(posedge clk);
        repeat (5) @(negedge clk);
`ifdef MEM_CRITICAL_WORD_FIRST_EN
        chk("lit_cwf_wn", wn_w[0], 3);
        chk("lit_cwf_data", data_w[0], 32'h8000_0403);
`else
        chk("lit_cwf_wn", wn_w[0], 0);
        chk("lit_cwf_data", data_w[0], 32'h8000_0400);
`endif
        req_w[0] = 0;
        wait_idle(0);

        // Reset pulse during beat 2, then a fresh request after release
        @(posedge clk); #1 req_w[0] = 1; raddr_w[0] = 32'h0000_2000;
        n = 0;
        while (!(rdy_w[0] === 1'b1 && wn_w[0] == 2'd2) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_beat2", (n < 20) ? 1 : 0, 1);
        #2 rst_w[0] = 0;
        #1;
        chk("lit_async_ready", rdy_w[0], 0);
        chk("lit_async_busy", busy_w[0], 0);
        bs = beats_seen[0];
        @(posedge clk);
        @(negedge clk);
        rst_w[0] = 1;
        repeat (2) @(negedge clk);
        req_w[0] = 0;
        wait_idle(0);
        chk("lit_post_rst_beats", beats_seen[0] - bs, 4);

        // LATENCY=4 with mem_req dropped right after acceptance
        bs = beats_seen[0];
        @(posedge clk); #1 req_w[0] = 1; raddr_w[0] = 32'h0000_4008;
        @(posedge clk); #1 req_w[0] = 0;
        wait_idle(0);
        chk("lit_drop_beats_l4", beats_seen[0] - bs, 4);

        // LATENCY=1, request dropped during WAIT
        @(posedge clk); #1 req_w[1] = 1; raddr_w[1] = 32'h0000_3004;
        @(posedge clk); #1 req_w[1] = 0;
        @(negedge clk);
        chk("lit_l1_c1_ready", rdy_w[1], 0);
        @(negedge clk);
        chk("lit_l1_c2_ready", rdy_w[1], 1);
        chk("lit_l1_c2_data", data_w[1], 32'h8000_0C00);
        wait_idle(1);
        chk("lit_l1_beats", beats_seen[1], 4);
        chk("lit_l1_idle", busy_w[1], 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 Parameter LATENCY, default 4, SHALL set the access delay in cycles; legal range 1..15.
REQ-002 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 mem_req  in  1  line-fill request, level; held by the requester until the final beat.
REQ-005 req_addr  in  32  physical byte address of the request; valid while mem_req is high.
REQ-006 mem_ready  out  1  beat-valid strobe, one cycle per beat.
REQ-007 mem_data  out  32  beat data; valid only while mem_ready is high.
REQ-008 write_num  out  2  beat index within the 16-byte line; valid while mem_ready is high.
REQ-009 busy_out  out  1  high whenever the state is not IDLE.
REQ-010 arr_rd_en  out  1  backing-array read strobe.
REQ-011 arr_addr  out  30  backing-array word address, {line_addr[31:4], word[1:0]}.
REQ-012 arr_data  in  32  array read data, returned exactly one cycle after arr_rd_en.

Function
REQ-013 The FSM SHALL have four states:
- IDLE: waiting for a request.
- WAIT: latency countdown.
- BURST: data beats.
- DONE: waiting for the request to drop.
REQ-014 In IDLE with mem_req=1, the block SHALL latch req_addr[31:2] and load the counter with LATENCY-1, then go to WAIT.
REQ-015 In WAIT, the counter SHALL decrement each cycle; at count 0 the block SHALL assert arr_rd_en for beat 0 and go to BURST.
REQ-016 In BURST, each cycle SHALL:
- assert mem_ready;
- drive mem_data=arr_data and write_num=current beat index;
- assert arr_rd_en for the next beat if one remains.
REQ-017 The first mem_ready SHALL occur LATENCY+1 cycles after the cycle in which mem_req was sampled in IDLE; the 4 beats SHALL occur in consecutive cycles, with no gaps.
REQ-018 After the 4th beat, the block SHALL go to DONE; DONE SHALL go to IDLE when mem_req=0 (four-phase handshake); DONE SHALL hold while mem_req=1.
REQ-019 If mem_req drops during WAIT or BURST, the block SHALL complete the full burst; it SHALL NOT abort.
REQ-020 A new request SHALL NOT be accepted before IDLE is re-entered; minimum request spacing is LATENCY+6 cycles.
REQ-021 mem_ready, arr_rd_en and busy_out SHALL be 0 in IDLE; mem_ready SHALL be 0 in WAIT and DONE.
REQ-022 The beat index SHALL increment modulo 4, wrapping 3 to 0.
REQ-023 arr_addr SHALL use the latched line address, never the live req_addr.

Reset
REQ-024 When reset_n=0, the block SHALL immediately force:
- state=IDLE;
- counter=0, beat count=0;
- mem_ready=0, arr_rd_en=0, busy_out=0;
- write_num=0, mem_data=0.
REQ-025 Reset asserted mid-burst SHALL drop mem_ready asynchronously with no further beats; after release, the block SHALL sample mem_req in the first clock edge in IDLE.

Configuration
REQ-026 With macro MEM_CRITICAL_WORD_FIRST_EN defined, the first beat index SHALL be req_addr[3:2], with subsequent beats wrapping modulo 4.
REQ-027 Without MEM_CRITICAL_WORD_FIRST_EN, the first beat index SHALL always be 0 and req_addr[3:2] SHALL be ignored.

Structure
REQ-028 Shared package mem_pkg SHALL hold:
- the state encoding: IDLE=2'b00, WAIT=2'b01, BURST=2'b10, DONE=2'b11;
- LINE_BEATS=4 and BEAT_W=32.
REQ-029 The latency countdown SHALL be the sub-module mem_latency_counter: 4-bit, with load, decrement and zero flag.

Verification
REQ-030 LATENCY=4, mem_req rises at cycle 0 with req_addr=0x0000_1000 -> mem_ready in cycles 5..8 with write_num 0,1,2,3 and arr_addr 0x400..0x403; busy_out high in cycles 1..9.
REQ-031 MEM_CRITICAL_WORD_FIRST_EN defined, req_addr=0x0000_100C -> write_num 3,0,1,2 and data from words 0x403,0x400,0x401,0x402; without the macro -> write_num 0,1,2,3.
REQ-032 mem_req held high 5 cycles after the last beat -> stays in DONE, busy_out=1, no mem_ready; mem_req low -> IDLE on the next edge, busy_out=0.
REQ-033 reset_n pulsed low during beat 2 -> mem_ready=0 within the same cycle, no further beats; a new request after release returns a full 4-beat burst.
REQ-034 LATENCY=1 -> first mem_ready exactly 2 cycles after the request; mem_req dropped during WAIT -> all 4 beats still delivered, then IDLE.
